// File: rtl/sobel_window_sched.sv
// Frame sequencer for the Sobel kernel: line-buffer addressing/rotation, 3x3 window strobes, result tagging.
// Optional frame/stall statistics are built when SOBEL_SCHED_STATS_EN is defined.
module sobel_window_sched #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ADDR_W     = 10,
    parameter int KERNEL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic              lb_wr_en_o,
    output logic [ADDR_W-1:0] lb_addr_o,
    output logic [1:0]        lb_wr_sel_o,
    output logic [1:0]        lb_ctr_sel_o,
    output logic              win_valid_o,
    output logic [ADDR_W-1:0] win_x_o,
    output logic [ADDR_W-1:0] win_y_o,
    output logic              border_o,
    output logic              out_valid_o,
    output logic              out_sof_o,
    output logic              out_eol_o,
    output logic              out_eof_o
`ifdef SOBEL_SCHED_STATS_EN
    ,
    output logic [15:0]       frame_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] in_x, in_y, cx, cy;
    logic              flush_end;
    logic              accept, row_wrap, last_pix, emit, start_acc;
    logic [3:0]        tag_in;
    logic [3:0]        dly_q [KERNEL_LAT];

    function automatic logic [1:0] sel_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    always_comb begin
        pix_ready_o = (state_q == S_PRIME) || (state_q == S_RUN);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE) && !abort_i;
        accept      = pix_valid_i && pix_ready_o;
        lb_wr_en_o  = accept;
        row_wrap    = accept && (in_x == X_LAST);
        last_pix    = row_wrap && (in_y == Y_LAST);
        // flush_end gives FLUSH one idle cycle so done_o trails the last window strobe
        emit        = ((state_q == S_RUN) && accept) || ((state_q == S_FLUSH) && !flush_end);
        start_acc   = (state_q == S_IDLE) && start_i && !abort_i;
        lb_addr_o   = '0;
        if (pix_ready_o) lb_addr_o = in_x;
        else if (state_q == S_FLUSH) lb_addr_o = cx;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_PRIME;
            S_PRIME: if (accept && (in_x == '0) && (in_y == ONE)) state_d = S_RUN;
            S_RUN:   if (last_pix) state_d = S_FLUSH;
            S_FLUSH: if (flush_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_x <= '0; in_y <= '0; cx <= '0; cy <= '0;
            lb_wr_sel_o <= '0; lb_ctr_sel_o <= '0; flush_end <= 1'b0;
            win_valid_o <= 1'b0; win_x_o <= '0; win_y_o <= '0; border_o <= 1'b0;
        end else if (abort_i || start_acc) begin
            in_x <= '0; in_y <= '0; cx <= '0; cy <= '0;
            lb_wr_sel_o <= '0; lb_ctr_sel_o <= '0; flush_end <= 1'b0;
            win_valid_o <= 1'b0; win_x_o <= '0; win_y_o <= '0; border_o <= 1'b0;
        end else begin
            if (accept) begin
                if (row_wrap) begin
                    in_x        <= '0;
                    in_y        <= (in_y == Y_LAST) ? '0 : in_y + ONE;
                    lb_wr_sel_o <= sel_inc(lb_wr_sel_o);
                end else begin
                    in_x <= in_x + ONE;
                end
            end
            win_valid_o <= emit;
            if (emit) begin
                win_x_o  <= cx;
                win_y_o  <= cy;
                border_o <= (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);
                if (cx == X_LAST) begin
                    cx           <= '0;
                    cy           <= (cy == Y_LAST) ? '0 : cy + ONE;
                    lb_ctr_sel_o <= sel_inc(lb_ctr_sel_o);
                    if (cy == Y_LAST) flush_end <= 1'b1;
                end else begin
                    cx <= cx + ONE;
                end
            end
        end
    end

    assign tag_in = {win_valid_o,
                     win_valid_o && (win_x_o == '0) && (win_y_o == '0),
                     win_valid_o && (win_x_o == X_LAST),
                     win_valid_o && (win_x_o == X_LAST) && (win_y_o == Y_LAST)};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < KERNEL_LAT; i++) dly_q[i] <= '0;
        end else if (abort_i) begin
            for (int unsigned i = 0; i < KERNEL_LAT; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= tag_in;
            for (int unsigned i = 1; i < KERNEL_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign out_valid_o = dly_q[KERNEL_LAT-1][3];
    assign out_sof_o   = dly_q[KERNEL_LAT-1][2];
    assign out_eol_o   = dly_q[KERNEL_LAT-1][1];
    assign out_eof_o   = dly_q[KERNEL_LAT-1][0];

`ifdef SOBEL_SCHED_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (done_o) frame_cnt_o <= frame_cnt_o + 16'd1;
            if (start_acc) stall_cnt_o <= '0;
            else if (pix_ready_o && !pix_valid_i && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_sobel_window_sched.sv
// Scoreboard bench for sobel_window_sched (4x3 frame, kernel latency 3), randomized pixel gaps.
module tb_sobel_window_sched;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int KL = 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_ni, start_i, abort_i, pix_valid_i;
    logic          busy_o, done_o, pix_ready_o, lb_wr_en_o;
    logic [AW-1:0] lb_addr_o, win_x_o, win_y_o;
    logic [1:0]    lb_wr_sel_o, lb_ctr_sel_o;
    logic          win_valid_o, border_o, out_valid_o, out_sof_o, out_eol_o, out_eof_o;
`ifdef SOBEL_SCHED_STATS_EN
    logic [15:0]   frame_cnt_o;
    logic [31:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    sobel_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .KERNEL_LAT(KL)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .lb_wr_en_o(lb_wr_en_o), .lb_addr_o(lb_addr_o), .lb_wr_sel_o(lb_wr_sel_o),
        .lb_ctr_sel_o(lb_ctr_sel_o), .win_valid_o(win_valid_o), .win_x_o(win_x_o),
        .win_y_o(win_y_o), .border_o(border_o), .out_valid_o(out_valid_o),
        .out_sof_o(out_sof_o), .out_eol_o(out_eol_o), .out_eof_o(out_eof_o)
`ifdef SOBEL_SCHED_STATS_EN
        , .frame_cnt_o(frame_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    typedef struct {
        int cyc;
        int tags;
    } tag_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   win_q[$];
    tag_t out_q[$];
    int   acc_cyc[N];
    int   acc_idx = 0;
    int   last_win_cyc = 0;
    int   exp_frames = 0;
    bit   in_frame = 0, expect_done = 0, done_seen = 0;
    bit   abort_mode = 0, abort_req = 0, chk_idle = 0;
    int   prev_ctr = 0, prev_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected window/result streams whenever the DUT presents them.
    always @(negedge clk) begin
        int c, x, y, ec, tg;
        tag_t t;
        if (rst_ni) begin
            check("pix_ready", int'(pix_ready_o), int'(in_frame && acc_idx < N));
            if (pix_valid_i && pix_ready_o && in_frame && acc_idx < N) begin
                check("wr_en", int'(lb_wr_en_o), 1);
                check("lb_addr", int'(lb_addr_o), acc_idx % W);
                check("wr_sel", int'(lb_wr_sel_o), (acc_idx / W) % 3);
                acc_cyc[acc_idx] = cyc;
                acc_idx++;
            end
            if (chk_idle) begin
                check("abort_busy", int'(busy_o), 0);
                chk_idle = 0;
            end
            if (win_valid_o) begin
                if (win_q.size() == 0) check("unexpected_window", 1, 0);
                else begin
                    c  = win_q.pop_front();
                    x  = c % W;
                    y  = c / W;
                    ec = (c <= N - W - 2) ? acc_cyc[c + W + 1] + 1 : acc_cyc[N - 1] + 1 + (c - (N - W - 2));
                    check("win_x", int'(win_x_o), x);
                    check("win_y", int'(win_y_o), y);
                    check("border", int'(border_o), int'(x == 0 || x == W - 1 || y == 0 || y == H - 1));
                    check("win_timing", cyc, ec);
                    check("ctr_sel", prev_ctr, y % 3);
                    if (c >= N - W - 1) check("flush_addr", prev_addr, x);
                    tg = ((x == 0 && y == 0) ? 4 : 0) + ((x == W - 1) ? 2 : 0)
                       + ((x == W - 1 && y == H - 1) ? 1 : 0);
                    out_q.push_back('{cyc + KL, tg});
                    if (c == N - 1) last_win_cyc = cyc;
                    if (abort_mode && x == 1 && y == 1) abort_req = 1;
                end
            end
            if (out_valid_o) begin
                if (out_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    t = out_q.pop_front();
                    check("out_timing", cyc, t.cyc);
                    check("out_tags", int'({out_sof_o, out_eol_o, out_eof_o}), t.tags);
                end
            end else begin
                check("tags_idle", int'({out_sof_o, out_eol_o, out_eof_o}), 0);
            end
            if (done_o) begin
                if (!expect_done) check("unexpected_done", 1, 0);
                else begin
                    check("done_timing", cyc, last_win_cyc + 1);
                    done_seen   = 1;
                    expect_done = 0;
                    in_frame    = 0;
                end
            end
            if (abort_i) begin
                win_q.delete();
                out_q.delete();
                in_frame    = 0;
                expect_done = 0;
                chk_idle    = 1;
            end
            prev_ctr  = int'(lb_ctr_sel_o);
            prev_addr = int'(lb_addr_o);
        end
    end

    task automatic begin_frame();
        start_i     = 1;
        pix_valid_i = 0;
        @(posedge clk); #1;
        start_i = 0;
        win_q.delete();
        out_q.delete();
        for (int c = 0; c < N; c++) win_q.push_back(c);
        acc_idx     = 0;
        done_seen   = 0;
        expect_done = 1;
        in_frame    = 1;
    endtask

    // mode 0: continuous, 1: alternating 1/0, 2: random gaps
    task automatic run_frame(input int mode, input bit do_abort, input bit dup_start);
        bit aborted;
        int t;
        begin_frame();
        abort_mode = do_abort;
        abort_req  = 0;
        aborted    = 0;
        t          = 0;
        while (!done_seen && !aborted && t < 200) begin
            case (mode)
                0:       pix_valid_i = 1;
                1:       pix_valid_i = (t % 2 == 0);
                default: pix_valid_i = ($urandom_range(0, 3) != 0);
            endcase
            start_i = dup_start && (t == 6 || t == 17);
            if (abort_req) begin
                abort_i = 1;
                aborted = 1;
            end
            @(posedge clk); #1;
            abort_i = 0;
            start_i = 0;
            t++;
        end
        check("frame_completed", int'(done_seen || aborted), 1);
        if (done_seen) exp_frames++;
        pix_valid_i = do_abort;
        repeat (KL + 3) begin
            @(posedge clk); #1;
        end
        pix_valid_i = 0;
        check("queues_drained", win_q.size() + out_q.size(), 0);
        abort_mode = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_ready"}, int'(pix_ready_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_win"}, int'({win_valid_o, win_x_o, win_y_o, border_o}), 0);
        check({tag, "_lb"}, int'({lb_wr_en_o, lb_addr_o, lb_wr_sel_o, lb_ctr_sel_o}), 0);
        check({tag, "_out"}, int'({out_valid_o, out_sof_o, out_eol_o, out_eof_o}), 0);
    endtask

    initial begin
        rst_ni = 0; start_i = 0; abort_i = 0; pix_valid_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1;
        check_all_zero("reset");

        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
`ifdef SOBEL_SCHED_STATS_EN
        check("stall_cnt", int'(stall_cnt_o), 11);
        check("frame_cnt", int'(frame_cnt_o), exp_frames);
`endif
        run_frame(2, 0, 1);
        run_frame(0, 1, 0);
        run_frame(0, 0, 0);
        repeat (3) run_frame(2, 0, 0);

        // asynchronous reset in the middle of RUN
        begin_frame();
        pix_valid_i = 1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst_ni = 0;
        #1;
        check_all_zero("async_reset");
        win_q.delete();
        out_q.delete();
        in_frame    = 0;
        expect_done = 0;
        @(posedge clk); #1;
        rst_ni = 1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_reset_ready", int'(pix_ready_o), 0);
            check("post_reset_busy", int'(busy_o), 0);
        end
        pix_valid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sobel_window_sched.md
Name: sobel_window_sched

Overview:
- Frame-level sequencer for the Sobel kernel datapath.
- Accepts a raster pixel stream and drives write/read addressing and rotation for the three line buffers.
- Issues one 3x3 window-valid strobe per pixel position, with centre coordinates and border flag, then flushes the final row.
- Tags the kernel's fixed-latency output with valid/SOF/EOL/EOF; sits between the pixel ingress and the kernel.

Parameters:
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- ADDR_W, 10, column/row counter width; 2**ADDR_W >= max(IMG_W, IMG_H)
- KERNEL_LAT, 3, kernel pipeline latency in cycles (>=1)

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  arm one frame; ignored unless IDLE
- abort_i  in  1  synchronous frame abort
- busy_o  out  1  high in any state but IDLE
- done_o  out  1  one-cycle pulse at frame completion
- pix_valid_i  in  1  input pixel valid
- pix_ready_o  out  1  input pixel accepted when valid&ready
- lb_wr_en_o  out  1  line-buffer write enable (= accept)
- lb_addr_o  out  ADDR_W  line-buffer column, read-before-write
- lb_wr_sel_o  out  2  buffer receiving current input row, 0..2
- lb_ctr_sel_o  out  2  buffer holding window centre row, 0..2
- win_valid_o  out  1  kernel window strobe
- win_x_o  out  ADDR_W  window centre column
- win_y_o  out  ADDR_W  window centre row
- border_o  out  1  centre on image edge; kernel forces 0
- out_valid_o  out  1  kernel result valid
- out_sof_o  out  1  result is (0,0)
- out_eol_o  out  1  result is column IMG_W-1
- out_eof_o  out  1  result is (IMG_W-1, IMG_H-1)

Behaviour:
- Reset (rst_ni low, async): state IDLE; all counters, selects, delay line and every output 0.
- States and transitions:
  - IDLE -> PRIME on start_i.
  - PRIME -> RUN once pixel index IMG_W (0-based raster index) is accepted.
  - RUN -> FLUSH once pixel index IMG_W*IMG_H-1 is accepted.
  - FLUSH -> DONE after IMG_W+1 flush windows.
  - DONE -> IDLE after one cycle; done_o=1 in DONE.
- pix_ready_o=1 only in PRIME/RUN. Input counters in_x/in_y advance per accept; in_x wraps at IMG_W-1.
- lb_wr_sel_o increments mod 3 on each row wrap. lb_ctr_sel_o lags by one row: increments mod 3 when win_x wraps, starts 0.
- lb_addr_o = in_x in PRIME/RUN; flush column counter in FLUSH.
- Windows:
  - Raster index k accepted in RUN -> win_valid_o=1 next cycle, centre = raster index k-(IMG_W+1).
  - FLUSH emits one window per cycle for the remaining IMG_W+1 centres.
  - Total windows per frame = IMG_W*IMG_H, strictly raster order, none in PRIME.
- Registered outputs: win_x_o, win_y_o, border_o.
- border_o = (cx==0)|(cx==IMG_W-1)|(cy==0)|(cy==IMG_H-1).
- Output tags: out_valid_o, out_sof_o, out_eol_o, out_eof_o are win_valid_o and the corresponding centre predicates delayed by exactly KERNEL_LAT cycles through a reset-to-0 shift register.
- pix_valid_i low: no accept, no window; counters hold.
- abort_i (highest priority after reset), in any state:
  - Next cycle: IDLE, counters and selects 0, delay line cleared.
  - No done_o. start_i in the same cycle is ignored.
- start_i while busy: ignored.
- done_o coincides with the last win_valid_o +1 cycle. out_eof_o follows KERNEL_LAT-1 cycles after done_o.

Optional Feature:
- Macro SOBEL_SCHED_STATS_EN.
- Defined: adds frame_cnt_o[15:0] and stall_cnt_o[31:0], both reset 0.
  - frame_cnt_o increments on done_o, wraps at 0xFFFF.
  - stall_cnt_o counts cycles in PRIME/RUN with pix_valid_i=0; cleared on start_i accepted; saturates at 0xFFFFFFFF.
- Undefined: neither port nor logic exists.

Test Plan:
- Reset values: rst_ni low mid-RUN -> all outputs 0 immediately; busy_o=0; pix_ready_o=0 until next start_i.
- Continuous frame, IMG_W=4, IMG_H=3, KERNEL_LAT=3, pix_valid_i=1:
  - First win_valid_o one cycle after 6th accept, centre (0,0).
  - 12 windows total, 5 of them in FLUSH.
  - done_o one cycle after 12th window.
  - out_sof_o 3 cycles after first window; 12 out_valid_o; out_eol_o on 3 results.
- Border check (same geometry): border_o=0 only for centres (1,1) and (2,1); other 10 windows border_o=1.
- Rotation: lb_wr_sel_o sequence 0,1,2 over rows 0..2. lb_ctr_sel_o 0,1,2 over centre rows 0..2.
- Gapped input: pix_valid_i toggling 1,0 -> windows only after accepts, raster order intact, 12 windows. With SOBEL_SCHED_STATS_EN: stall_cnt_o=11, frame_cnt_o=1.
- Abort/start:
  - abort_i during RUN at centre (1,1) -> IDLE next cycle, no done_o, no further out_valid_o.
  - New start_i then gives a clean 12-window frame.
  - start_i pulsed while busy -> no effect.
